// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transfer sequencer: FSM state encoding,
// simple_spi_top register map, and SPCR/SPSR bit positions.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_SPER,
    S_WR_SPCR,
    S_CS_ON,
    S_WAIT_TX,
    S_WR_SPDR,
    S_POLL,
    S_RD_SPDR,
    S_CS_OFF,
    S_DONE
  } state_e;

  localparam logic [1:0] ADR_SPCR = 2'd0;
  localparam logic [1:0] ADR_SPSR = 2'd1;
  localparam logic [1:0] ADR_SPDR = 2'd2;
  localparam logic [1:0] ADR_SPER = 2'd3;

  localparam int SPSR_SPIF = 7;
  localparam int SPCR_SPE  = 6;
  localparam int SPCR_MSTR = 4;
  localparam int SPCR_CPOL = 3;
  localparam int SPCR_CPHA = 2;

  // Writing 1 to SPIF clears it in simple_spi_top.
  localparam logic [7:0] SPSR_CLR = 8'h80;

  function automatic logic [7:0] spcr_value(input logic cpol, input logic cpha,
                                            input logic [1:0] spr);
    logic [7:0] v;
    v            = 8'h00;
    v[SPCR_SPE]  = 1'b1;
    v[SPCR_MSTR] = 1'b1;
    v[SPCR_CPOL] = cpol;
    v[SPCR_CPHA] = cpha;
    v[1:0]       = spr;
    return v;
  endfunction

  // States that own a bus access (and therefore an ack wait).
  function automatic logic is_access(input state_e s);
    return (s == S_WR_SPER) || (s == S_WR_SPCR) || (s == S_WR_SPDR) ||
           (s == S_POLL)    || (s == S_RD_SPDR);
  endfunction

endpackage

// File: rtl/spi_seq_wb_access.sv
// Single-access Wishbone engine: latches a request, holds cyc/stb/adr/we/dat
// until ack_i, then drops the strobes so consecutive accesses get an idle gap.
module spi_seq_wb_access (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req,
  input  logic       abort,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       cyc_o,
  output logic       stb_o,
  output logic [1:0] adr_o,
  output logic       we_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  logic       cyc_q, cyc_d;
  logic [1:0] adr_q, adr_d;
  logic       we_q, we_d;
  logic [7:0] dat_q, dat_d;

  // A request is only taken while idle, so the cycle right after an ack is
  // always idle on the bus even if the FSM asks again immediately.
  always_comb begin
    cyc_d = cyc_q;
    adr_d = adr_q;
    we_d  = we_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (ack_i || abort) cyc_d = 1'b0;
    end else if (req && !abort) begin
      cyc_d = 1'b1;
      adr_d = addr;
      we_d  = we;
      dat_d = wdata;
    end
  end

  // NOTE: state flops use non-blocking assignments only; all next-state
  // values come from the always_comb above, which assigns defaults first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q <= 1'b0;
      adr_q <= 2'd0;
      we_q  <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      cyc_q <= cyc_d;
      adr_q <= adr_d;
      we_q  <= we_d;
      dat_q <= dat_d;
    end
  end

  assign ack   = cyc_q & ack_i;
  assign rdata = dat_i;
  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign adr_o = adr_q;
  assign we_o  = we_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Runs complete multi-byte SPI transactions on simple_spi_top over Wishbone.
// Optional access/poll timeout is enabled with `define SPI_SEQ_TIMEOUT_EN.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [1:0] SPR      = 2'b00,
  parameter logic [1:0] ESPR     = 2'b00,
  parameter logic       CPOL     = 1'b0,
  parameter logic       CPHA     = 1'b0,
  parameter int         CS_SETUP = 4,
  parameter int         TIMEOUT  = 1023
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_len,
  input  logic [1:0] cmd_cs,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       error,
  output logic       cyc_o,
  output logic       stb_o,
  output logic [1:0] adr_o,
  output logic       we_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  output logic [1:0] spi_cs_o
);

  // One counter serves the CS setup/hold waits and the ack/poll timeout;
  // they never run at the same time.
  localparam int CNT_MAX = (TIMEOUT > CS_SETUP) ? TIMEOUT : CS_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(CS_SETUP - 1);

  state_e           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [1:0]       cs_q, cs_d;
  logic [1:0]       spi_cs_q, spi_cs_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       wb_req, wb_abort, wb_we, wb_ack;
  logic [1:0] wb_addr;
  logic [7:0] wb_wdata, wb_rdata;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT - 1);
  logic tmo_hit;
  logic error_q, error_d;

  assign tmo_hit  = is_access(state_q) && !wb_ack && (cnt_q >= TMO_LIM);
  assign wb_abort = tmo_hit;

  always_comb begin
    error_d = error_q;
    if (state_q == S_IDLE && cmd_valid) error_d = 1'b0;
    if (tmo_hit) error_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) error_q <= 1'b0;
    else        error_q <= error_d;
  end

  assign error = error_q;
`else
  assign wb_abort = 1'b0;
  assign error    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cs_d       = cs_q;
    spi_cs_d   = spi_cs_q;
    tx_byte_d  = tx_byte_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    clr_d      = clr_q;
    cnt_d      = cnt_q;
    wb_req     = is_access(state_q);
    wb_addr    = ADR_SPCR;
    wb_we      = 1'b0;
    wb_wdata   = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rem_d   = cmd_len;
          cs_d    = cmd_cs;
          state_d = S_WR_SPER;
        end
      end
      S_WR_SPER: begin
        wb_addr  = ADR_SPER;
        wb_we    = 1'b1;
        wb_wdata = {6'b0, ESPR};
        if (wb_ack) state_d = S_WR_SPCR;
      end
      S_WR_SPCR: begin
        wb_addr  = ADR_SPCR;
        wb_we    = 1'b1;
        wb_wdata = spcr_value(CPOL, CPHA, SPR);
        if (wb_ack) begin
          spi_cs_d = cs_q;
          state_d  = S_CS_ON;
        end
      end
      S_CS_ON: begin
        if (cnt_q == SETUP_LIM) begin
          cnt_d   = '0;
          state_d = S_WAIT_TX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_TX: begin
        if (tx_valid) begin
          tx_byte_d = tx_data;
          state_d   = S_WR_SPDR;
        end
      end
      S_WR_SPDR: begin
        wb_addr  = ADR_SPDR;
        wb_we    = 1'b1;
        wb_wdata = tx_byte_q;
        if (wb_ack) state_d = S_POLL;
      end
      S_POLL: begin
        wb_addr = ADR_SPSR;
        if (wb_ack && wb_rdata[SPSR_SPIF]) begin
          clr_d   = 1'b0;
          state_d = S_RD_SPDR;
        end
      end
      S_RD_SPDR: begin
        // Sub-step 0 reads the received byte, sub-step 1 clears SPIF.
        if (!clr_q) begin
          wb_addr = ADR_SPDR;
          if (wb_ack) begin
            rx_data_d  = wb_rdata;
            rx_valid_d = 1'b1;
            clr_d      = 1'b1;
          end
        end else begin
          wb_addr  = ADR_SPSR;
          wb_we    = 1'b1;
          wb_wdata = SPSR_CLR;
          if (wb_ack) begin
            clr_d = 1'b0;
            if (rem_q == 8'd0) begin
              state_d = S_CS_OFF;
            end else begin
              rem_d   = rem_q - 8'd1;
              state_d = S_WAIT_TX;
            end
          end
        end
      end
      S_CS_OFF: begin
        if (cnt_q == SETUP_LIM) begin
          cnt_d    = '0;
          spi_cs_d = 2'b11;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef SPI_SEQ_TIMEOUT_EN
    // Restart on every ack, except non-final SPSR polls so a stuck SPIF still times out.
    if (is_access(state_q)) begin
      if (wb_ack && (state_q != S_POLL || wb_rdata[SPSR_SPIF])) cnt_d = '0;
      else                                                      cnt_d = cnt_q + CNT_W'(1);
    end
    if (tmo_hit) begin
      cnt_d   = '0;
      clr_d   = 1'b0;
      state_d = S_CS_OFF;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      rem_q      <= 8'd0;
      cs_q       <= 2'b11;
      spi_cs_q   <= 2'b11;
      tx_byte_q  <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      clr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cs_q       <= cs_d;
      spi_cs_q   <= spi_cs_d;
      tx_byte_q  <= tx_byte_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      clr_q      <= clr_d;
      cnt_q      <= cnt_d;
    end
  end

  spi_seq_wb_access u_wb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (wb_req),
    .abort (wb_abort),
    .addr  (wb_addr),
    .we    (wb_we),
    .wdata (wb_wdata),
    .ack   (wb_ack),
    .rdata (wb_rdata),
    .cyc_o (cyc_o),
    .stb_o (stb_o),
    .adr_o (adr_o),
    .we_o  (we_o),
    .dat_o (dat_o),
    .dat_i (dat_i),
    .ack_i (ack_i)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign tx_ready  = (state_q == S_WAIT_TX);
  assign done      = (state_q == S_DONE);
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign spi_cs_o  = spi_cs_q;

endmodule
